// File: rtl/core_pio_sequencer.sv
// core_pio_sequencer: Avalon-MM pattern sequencer driving a 10-bit registered output port
module core_pio_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [9:0]  out_port,
  output logic        irq
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [9:0] data_r;
  logic [9:0] pat [4];
  logic loop, irq_en, done;
  logic [1:0] last, step;
  logic [23:0] period, period_eff, cnt;
  logic wr, wr_ctl, expire, start, abort, fin, adv;
  assign wr = chipselect & ~write_n;
  assign wr_ctl = wr && address == 3'd1;
  assign period_eff = (period == '0) ? 24'd1 : period;
  assign expire = state == RUN && cnt <= 24'd1;
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // Next state: start, abort, and step expiry (LAST lowered below STEP counts as last)
  always_comb begin
    state_n = state;
    start = 1'b0;
    abort = 1'b0;
    fin = 1'b0;
    adv = 1'b0;
    if (state == IDLE) begin
      start = wr_ctl & writedata[0];
      state_n = start ? RUN : IDLE;
    end else if (wr_ctl && !writedata[0]) begin
      abort = 1'b1;
      state_n = IDLE;
    end else if (expire) begin
      fin = (step >= last) && !loop;
      adv = !fin;
      state_n = fin ? IDLE : RUN;
    end
  end
  // Software-visible configuration registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_r <= '0;
      loop <= 1'b0;
      irq_en <= 1'b0;
      last <= '0;
      period <= '0;
      for (int i = 0; i < 4; i++) pat[i] <= '0;
    end else begin
      if (wr && address == 3'd0) data_r <= writedata[9:0];
      if (wr_ctl) {last, irq_en, loop} <= {writedata[5:4], writedata[2], writedata[1]};
      if (wr && address == 3'd2) period <= writedata[23:0];
      if (wr && address[2]) pat[address[1:0]] <= writedata[9:0];
    end
  // Step counter, step index, completion flag and registered outputs
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      step <= '0;
      done <= 1'b0;
      out_port <= '0;
      irq <= 1'b0;
    end else begin
      if (start || adv) cnt <= period_eff;
      else if (abort || fin) cnt <= '0;
      else if (state == RUN) cnt <= cnt - 24'd1;
      if (start || abort || fin) step <= '0;
      else if (adv) step <= (step >= last) ? 2'd0 : step + 2'd1;
      done <= fin | (done & ~(wr && address == 3'd3 && writedata[1]));
      out_port <= (state == RUN) ? pat[step] : data_r;
      irq <= done & irq_en;
    end
  // Zero-wait-state read mux; RUN reads back the live FSM state
  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata = {22'd0, data_r};
      3'd1: readdata = {26'd0, last, 1'b0, irq_en, loop, state == RUN};
      3'd2: readdata = {8'd0, period};
      3'd3: readdata = {26'd0, step, 2'b00, done, state == RUN};
      default: readdata = {22'd0, pat[address[1:0]]};
    endcase
  end
endmodule

// File: tb/tb_core_pio_sequencer.sv
// tb_core_pio_sequencer: directed scoreboard bench for core_pio_sequencer
module tb_core_pio_sequencer;
  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0] out_port;
  logic irq;
  logic [9:0] exp_q [$];
  logic [9:0] e;
  logic [31:0] r;
  int n_assert = 0;
  int n_fail = 0;
  core_pio_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .irq(irq)
  );
  always #5 clk = ~clk;
  // Per-cycle out_port scoreboard, sampled mid-cycle
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (out_port === e) else begin
        n_fail++;
        $error("FAIL out_port_seq: got %h expected %h", out_port, e);
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask
  task automatic push(input logic [9:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
    end
    exp_q.delete();
    #1;
  endtask
  initial begin
    reset_n = 1'b0;
    address = '0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {22'd0, out_port}, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    rd(3'd3, r);
    chk("reset_status", r, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    wr(3'd0, 32'h2A5);
    @(posedge clk);
    #1;
    chk("data_out", {22'd0, out_port}, 32'h2A5);
    rd(3'd0, r);
    chk("data_read", r, 32'h2A5);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h2);
    wr(3'd6, 32'h4);
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h21);
    push(10'h2A5, 1);
    push(10'h001, 3);
    push(10'h002, 3);
    push(10'h004, 3);
    push(10'h2A5, 2);
    drain("oneshot");
    rd(3'd3, r);
    chk("oneshot_status", r, 32'h2);
    rd(3'd1, r);
    chk("oneshot_ctrl", r, 32'h20);
    chk("oneshot_irq", {31'd0, irq}, 32'h0);
    wr(3'd3, 32'h2);
    rd(3'd3, r);
    chk("done_clear", r, 32'h0);
    wr(3'd1, 32'h27);
    push(10'h2A5, 1);
    for (int k = 0; k < 2; k++) begin
      push(10'h001, 3);
      push(10'h002, 3);
      push(10'h004, 3);
    end
    drain("loop");
    chk("loop_irq", {31'd0, irq}, 32'h0);
    wr(3'd1, 32'h0);
    rd(3'd3, r);
    chk("abort_status", r, 32'h0);
    @(posedge clk);
    #1;
    chk("abort_out", {22'd0, out_port}, 32'h2A5);
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h15);
    push(10'h2A5, 1);
    push(10'h001, 1);
    push(10'h002, 1);
    push(10'h2A5, 1);
    @(posedge clk);
    #1;
    wr(3'd3, 32'h2);
    rd(3'd3, r);
    chk("set_wins_status", r, 32'h2);
    @(posedge clk);
    #1;
    chk("p0_irq", {31'd0, irq}, 32'h1);
    drain("period0");
    wr(3'd3, 32'h2);
    @(posedge clk);
    #1;
    chk("irq_clear", {31'd0, irq}, 32'h0);
    wr(3'd2, 32'h4);
    wr(3'd1, 32'h21);
    repeat (4) @(posedge clk);
    #1;
    rd(3'd3, r);
    chk("pre_reset_status", r, 32'h11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_out", {22'd0, out_port}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rd(3'd3, r);
    chk("rst_status", r, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out", {22'd0, out_port}, 32'h0);
    wr(3'd0, 32'h155);
    @(posedge clk);
    #1;
    chk("post_rst_data", {22'd0, out_port}, 32'h155);
    wr(3'd4, 32'h011);
    wr(3'd5, 32'h022);
    wr(3'd6, 32'h033);
    wr(3'd2, 32'h3);
    wr(3'd1, 32'h21);
    push(10'h155, 1);
    push(10'h011, 3);
    push(10'h3FF, 5);
    push(10'h033, 5);
    push(10'h155, 2);
    wr(3'd5, 32'h3FF);
    wr(3'd2, 32'h5);
    drain("live_update");
    rd(3'd3, r);
    chk("live_status", r, 32'h2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/core_pio_sequencer.md
CORE_PIO_SEQUENCER -- requirements
Module: core_pio_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk is the only clock; reset_n is asynchronous, active-low.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-005 SHALL have port chipselect, input, 1 bit: slave select.
REQ-006 SHALL have port write_n, input, 1 bit: active-low write strobe; a write is chipselect && ~write_n.
REQ-007 SHALL have port writedata, input, 32 bits: write data.
REQ-008 SHALL have port readdata, output, 32 bits: combinational read data, zero wait states, unused bits 0.
REQ-009 SHALL have port out_port, output, 10 bits: registered pin output.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-011 Register map SHALL be:
- 0 DATA: RW, [9:0] manual value.
- 1 CONTROL: RW; bit0 RUN, bit1 LOOP, bit2 IRQ_EN, [5:4] LAST (last step index).
- 2 PERIOD: RW, [23:0] cycles per step.
- 3 STATUS: RO except DONE; bit0 BUSY, bit1 DONE (write 1 clears), [5:4] STEP.
- 4..7: PATTERN0..3, RW, [9:0].
REQ-012 Reads SHALL return the stored register bits; reads of RUN SHALL return the live bit, which auto-clears at completion.
REQ-013 FSM states SHALL be IDLE and RUN; BUSY = (state == RUN).
REQ-014 In IDLE, out_port SHALL equal DATA, updated the cycle after a DATA write.
REQ-015 A CONTROL write with RUN=1 in IDLE SHALL enter RUN at that edge, with STEP=0 and the step counter loaded with PERIOD; out_port = PATTERN0 from the next cycle.
REQ-016 PERIOD=0 SHALL be treated as 1.
REQ-017 Each step SHALL drive out_port = PATTERN[STEP] for exactly max(PERIOD,1) cycles, then advance.
REQ-018 At expiry with STEP<LAST: STEP increments, counter reloads PERIOD (value sampled at reload), out_port = PATTERN[STEP+1].
REQ-019 At expiry with STEP==LAST and LOOP=1: STEP wraps to 0 with no gap cycle.
REQ-020 At expiry with STEP==LAST and LOOP=0: state -> IDLE, RUN clears, DONE sets, STEP -> 0, out_port = DATA next cycle.
REQ-021 A CONTROL write with RUN=0 during RUN SHALL abort to IDLE at that edge; DONE is not set.
REQ-022 A CONTROL write with RUN=1 during RUN SHALL update LOOP, IRQ_EN and LAST only; the sequence is not restarted.
REQ-023 If LAST is lowered below STEP, the current step SHALL be treated as the last.
REQ-024 PATTERN writes during RUN SHALL take effect on the next cycle out_port loads that entry.
REQ-025 irq SHALL equal DONE && IRQ_EN, registered.
REQ-026 If a DONE set and a DONE write-1-clear occur in the same cycle, the set SHALL win.

Reset
REQ-027 On reset_n=0 all registers, the FSM (IDLE), the counter, STEP, out_port, irq and DONE SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-sequence SHALL abort immediately with no DONE; out_port = 0 until written.

Verification
REQ-029 Reset, then write DATA=0x2A5 -> out_port=0x2A5 one cycle later; readdata at address 0 = 0x2A5.
REQ-030 Write PATTERN0..2=0x001/0x002/0x004, PERIOD=3, CONTROL=0x21 (LAST=2, RUN) -> out_port 0x001,0x002,0x004 for 3 cycles each, then DATA; DONE=1; RUN reads 0; irq=0.
REQ-031 Same as REQ-030 with CONTROL=0x27 (LOOP, IRQ_EN) -> pattern repeats with no gap, irq stays 0; then write CONTROL=0 -> IDLE next cycle, DONE=0.
REQ-032 PERIOD=0, LAST=1, IRQ_EN set -> each step lasts 1 cycle, irq=1 after completion; write STATUS=0x2 in the DONE-set cycle -> DONE remains 1.
REQ-033 Assert reset_n low mid-step, STEP=1 -> out_port, STATUS, irq = 0 immediately; after release, DATA write is honored.
REQ-034 During RUN, write PATTERN1=0x3FF while STEP=0 -> step 1 shows 0x3FF; write PERIOD=5 -> the next reloaded step lasts 5 cycles.
